display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter DWELL, default 50_000_000, meaning the minimum cycles a granted client's message stays on the display.
REQ-002 SHALL have parameter CW, default $clog2(DWELL)+1, meaning the dwell counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the asynchronous active-high reset.
REQ-005 SHALL have port req, input, 2, meaning per-client display request, where bit i is client i.
REQ-006 SHALL have ports data0/data1, input, 32, meaning per-client hex nibbles, with digit k at bits [4k+3:4k].
REQ-007 SHALL have ports digits0/digits1, input, 8, meaning per-client digit-enable masks.
REQ-008 SHALL have ports points0/points1, input, 8, meaning per-client decimal-point masks.
REQ-009 SHALL have port grant, output, 2, meaning a one-hot grant that is 0 when no client is granted.
REQ-010 SHALL have port disp_data, output, 32, meaning the nibbles driven to the seven-segment controller data input.
REQ-011 SHALL have port disp_digits, output, 8, meaning the digit-enable mask driven to the controller.
REQ-012 SHALL have port disp_points, output, 8, meaning the decimal-point mask driven to the controller.
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SHOW and HANDOFF, and track two registers: owner (1 bit) and last (1 bit, the last client served).
REQ-015 In IDLE with req!=0, SHALL go to SHOW on the next edge, with grant asserted that same edge (1-cycle req-to-grant latency).
REQ-016 The IDLE winner SHALL be the single requester; if both clients request, the winner SHALL be ~last (round-robin).
REQ-017 On entry to SHOW, SHALL set owner=winner and last=winner, and clear the dwell counter to 0.
REQ-018 While in SHOW, disp_* SHALL register the owner's data/digits/points every cycle (1-cycle latency, live updates allowed).
REQ-019 In SHOW, the dwell counter SHALL increment each cycle and saturate at DWELL-1; "expired" means the counter equals DWELL-1.
REQ-020 If the owner drops req before expiry, SHALL keep grant and the display until expiry (minimum-dwell guarantee).
REQ-021 At expiry, if the other client is requesting, SHALL go to HANDOFF, regardless of the owner's req.
REQ-022 At expiry with only the owner requesting, SHALL stay in SHOW with the counter held saturated; a later request from the other client SHALL cause HANDOFF on the next edge.
REQ-023 At expiry with no requests, SHALL go to IDLE.
REQ-024 In HANDOFF, SHALL hold grant=0 for exactly one cycle while disp_* hold their values, then enter SHOW for the other client.
REQ-025 In HANDOFF, if the other client has dropped req by then, SHALL enter SHOW for the old owner if it is requesting, otherwise go to IDLE.
REQ-026 In IDLE, SHALL drive disp_digits=0 (blank) and hold disp_data/disp_points at their last values.
REQ-027 SHALL never assert more than one grant bit; grant SHALL be a registered output.
REQ-028 When DWELL=1, a SHOW state SHALL last at least 1 cycle before HANDOFF is possible.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, owner=0, last=1 (client 0 wins first tie), counter=0, grant=0, disp_data=0, disp_digits=0, disp_points=0 and busy=0.
REQ-030 Reset asserted mid-SHOW or mid-HANDOFF SHALL abort without a completion cycle; after release, arbitration SHALL restart from IDLE.

Structure
REQ-031 Package display_pkg SHALL hold the state enum (IDLE, SHOW, HANDOFF), NUM_CLIENTS=2 and NUM_DIGITS=8.
REQ-032 Sub-module dwell_timer SHALL hold the clear/increment/saturating counter and expose an expired flag; all other logic SHALL stay in display_arbiter.

Verification (DWELL=4)
REQ-033 With req=01 from reset, data0=32'h1234_5678 and digits0=8'hFF: grant SHALL be 01 one edge later, with disp_data=32'h12345678 and disp_digits=8'hFF one edge after that.
REQ-034 With req=11 from reset: grant SHALL be 01 for 4 cycles, 00 for 1 cycle, then 10; after B's dwell with req=11, grant SHALL return to 01.
REQ-035 With req=01 pulsed for 1 cycle: grant SHALL stay 01 for 4 cycles, then the FSM SHALL enter IDLE, with disp_digits=0 and busy=0.
REQ-036 With rst asserted while grant=10 mid-dwell: grant, disp_* and busy SHALL go 0 without waiting for a clock; with req=11 after release, grant SHALL be 01.
REQ-037 With data0 changed to 32'hDEAD_BEEF during client 0's SHOW: disp_data SHALL show 32'hDEADBEEF one cycle later.
REQ-038 With req=11 and client 1 dropping req during HANDOFF: the FSM SHALL re-enter SHOW for client 0 with grant=01.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and sizes for the two-client seven-segment display arbiter.
package display_pkg;

  localparam int NUM_CLIENTS = 2;
  localparam int NUM_DIGITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    HANDOFF
  } state_t;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Minimum-dwell counter: cleared on a new grant, saturates at DWELL-1.
module dwell_timer #(
  parameter int DWELL = 50_000_000,
  parameter int CW    = $clog2(DWELL) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one seven-segment controller
// between two clients, with a guaranteed minimum dwell per grant.
module display_arbiter
  import display_pkg::*;
#(
  parameter int DWELL = 50_000_000,
  parameter int CW    = $clog2(DWELL) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CLIENTS-1:0]  req,
  input  logic [4*NUM_DIGITS-1:0] data0,
  input  logic [4*NUM_DIGITS-1:0] data1,
  input  logic [NUM_DIGITS-1:0]   digits0,
  input  logic [NUM_DIGITS-1:0]   digits1,
  input  logic [NUM_DIGITS-1:0]   points0,
  input  logic [NUM_DIGITS-1:0]   points1,
  output logic [NUM_CLIENTS-1:0]  grant,
  output logic [4*NUM_DIGITS-1:0] disp_data,
  output logic [NUM_DIGITS-1:0]   disp_digits,
  output logic [NUM_DIGITS-1:0]   disp_points,
  output logic                    busy
);

  state_t state;
  logic   owner;
  logic   last;
  logic   expired;
  logic   start;
  logic   win;
  logic   own_req;
  logic   other_req;

  logic [4*NUM_DIGITS-1:0] sel_data;
  logic [NUM_DIGITS-1:0]   sel_digits;
  logic [NUM_DIGITS-1:0]   sel_points;

  always_comb begin
    own_req    = req[owner];
    other_req  = req[~owner];
    sel_data   = owner ? data1   : data0;
    sel_digits = owner ? digits1 : digits0;
    sel_points = owner ? points1 : points0;
    start      = 1'b0;
    win        = owner;
    unique case (state)
      IDLE: begin
        start = |req;
        win   = &req ? ~last : req[1];
      end
      // The waiting client has priority; the old owner only keeps
      // the display if the other side gave up during the gap.
      HANDOFF: begin
        start = |req;
        win   = other_req ? ~owner : owner;
      end
      default: ;
    endcase
  end

  dwell_timer #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .en      (state == SHOW),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      grant       <= '0;
      disp_data   <= '0;
      disp_digits <= '0;
      disp_points <= '0;
    end else begin
      unique case (state)
        IDLE, HANDOFF: begin
          if (start) begin
            state <= SHOW;
            owner <= win;
            last  <= win;
            grant <= onehot(win);
          end else begin
            state       <= IDLE;
            disp_digits <= '0;
          end
        end
        SHOW: begin
          disp_data   <= sel_data;
          disp_points <= sel_points;
          disp_digits <= sel_digits;
          if (expired) begin
            if (other_req) begin
              state <= HANDOFF;
              grant <= '0;
            end else if (!own_req) begin
              state       <= IDLE;
              grant       <= '0;
              disp_digits <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter (DWELL=4): directed table, corner sequences, random vs model.
module tb_display_arbiter;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [7:0]  digits0 = '0;
  logic [7:0]  digits1 = '0;
  logic [7:0]  points0 = '0;
  logic [7:0]  points1 = '0;
  logic [1:0]  grant;
  logic [31:0] disp_data;
  logic [7:0]  disp_digits;
  logic [7:0]  disp_points;
  logic        busy;

  display_arbiter #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .digits0     (digits0),
    .digits1     (digits1),
    .points0     (points0),
    .points1     (points1),
    .grant       (grant),
    .disp_data   (disp_data),
    .disp_digits (disp_digits),
    .disp_points (disp_points),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0=idle, 1=showing, 2=gap between owners.
  int          m_phase;
  bit          m_owner;
  bit          m_last;
  int          m_age;
  logic [1:0]  e_grant;
  logic [31:0] e_data;
  logic [7:0]  e_dig;
  logic [7:0]  e_pts;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_age = 0;
    e_grant = 0; e_data = 0; e_dig = 0; e_pts = 0;
  endtask

  task automatic model_grant(input bit w);
    m_phase = 1; m_owner = w; m_last = w; m_age = 0;
    e_grant = w ? 2'b10 : 2'b01;
  endtask

  task automatic model_step();
    bit w;
    bit exp_d;
    case (m_phase)
      0: if (req != 0) begin
        w = (req == 2'b11) ? !m_last : req[1];
        model_grant(w);
      end
      1: begin
        e_data = m_owner ? data1 : data0;
        e_pts  = m_owner ? points1 : points0;
        e_dig  = m_owner ? digits1 : digits0;
        exp_d  = (m_age >= DWELL - 1);
        if (!exp_d) m_age++;
        if (exp_d) begin
          if (req[!m_owner]) begin
            m_phase = 2; e_grant = 0;
          end else if (!req[m_owner]) begin
            m_phase = 0; e_grant = 0; e_dig = 0;
          end
        end
      end
      default: begin
        if (req[!m_owner]) model_grant(!m_owner);
        else if (req[m_owner]) model_grant(m_owner);
        else begin
          m_phase = 0; e_dig = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string nm);
    chk({nm, ".grant"}, 64'(grant), 64'(e_grant));
    chk({nm, ".busy"}, 64'(busy), 64'(m_phase != 0));
    chk({nm, ".digits"}, 64'(disp_digits), 64'(e_dig));
    chk({nm, ".data"}, 64'(disp_data), 64'(e_data));
    chk({nm, ".points"}, 64'(disp_points), 64'(e_pts));
    chk({nm, ".onehot"}, 64'($countones(grant) <= 1), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] grant;
    logic       busy;
    logic [7:0] digits;
  } vec_t;

  vec_t tbl[38];

  initial begin
    tbl[0]  = '{2'b11, 2'b01, 1'b1, 8'h00};
    tbl[1]  = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[2]  = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[3]  = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 8'hFF};
    tbl[5]  = '{2'b11, 2'b10, 1'b1, 8'hFF};
    tbl[6]  = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[7]  = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[8]  = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 8'h0F};
    tbl[10] = '{2'b11, 2'b01, 1'b1, 8'h0F};
    tbl[11] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[12] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[13] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 8'h00};
    tbl[15] = '{2'b01, 2'b01, 1'b1, 8'h00};
    tbl[16] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[17] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[18] = '{2'b00, 2'b01, 1'b1, 8'hFF};
    tbl[19] = '{2'b00, 2'b00, 1'b0, 8'h00};
    tbl[20] = '{2'b11, 2'b10, 1'b1, 8'h00};
    tbl[21] = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[22] = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[23] = '{2'b11, 2'b10, 1'b1, 8'h0F};
    tbl[24] = '{2'b11, 2'b00, 1'b1, 8'h0F};
    tbl[25] = '{2'b10, 2'b10, 1'b1, 8'h0F};
    tbl[26] = '{2'b10, 2'b10, 1'b1, 8'h0F};
    tbl[27] = '{2'b10, 2'b10, 1'b1, 8'h0F};
    tbl[28] = '{2'b10, 2'b10, 1'b1, 8'h0F};
    tbl[29] = '{2'b10, 2'b10, 1'b1, 8'h0F};
    tbl[30] = '{2'b11, 2'b00, 1'b1, 8'h0F};
    tbl[31] = '{2'b11, 2'b01, 1'b1, 8'h0F};
    tbl[32] = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[33] = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[34] = '{2'b11, 2'b01, 1'b1, 8'hFF};
    tbl[35] = '{2'b11, 2'b00, 1'b1, 8'hFF};
    tbl[36] = '{2'b01, 2'b01, 1'b1, 8'hFF};
    tbl[37] = '{2'b00, 2'b01, 1'b1, 8'hFF};

    data0   = 32'h1234_5678; digits0 = 8'hFF; points0 = 8'h01;
    data1   = 32'hAABB_CCDD; digits1 = 8'h0F; points1 = 8'h80;

    // Reset state
    do_reset();
    chk("reset", {grant, busy, disp_digits, disp_points, disp_data},
        {2'b00, 1'b0, 8'h00, 8'h00, 32'h0});

    // Directed table: round robin, pulse to idle, handoff corners
    for (int i = 0; i < 38; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("row%0d", i), {grant, busy, disp_digits},
          {tbl[i].grant, tbl[i].busy, tbl[i].digits});
      if (tbl[i].digits == 8'hFF)
        chk($sformatf("row%0d.data", i), {disp_data, disp_points},
            {data0, points0});
      else if (tbl[i].digits == 8'h0F)
        chk($sformatf("row%0d.data", i), {disp_data, disp_points},
            {data1, points1});
    end

    // Asynchronous reset while client 1 is mid-dwell
    do_reset();
    req = 2'b10;
    tick();
    tick();
    chk("pre_rst.grant", 64'(grant), 64'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {grant, busy, disp_digits, disp_points, disp_data},
        {2'b00, 1'b0, 8'h00, 8'h00, 32'h0});
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("post_rst.grant", 64'(grant), 64'(2'b01));

    // Live data update while client 0 is shown
    do_reset();
    req = 2'b01;
    tick();
    tick();
    chk("live.before", 64'(disp_data), 64'(32'h1234_5678));
    data0 = 32'hDEAD_BEEF;
    tick();
    chk("live.after", 64'(disp_data), 64'(32'hDEAD_BEEF));

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rand_rst");
        rst = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) data0 = $urandom;
      if ($urandom_range(0, 7) == 0) data1 = $urandom;
      if ($urandom_range(0, 9) == 0) digits0 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) digits1 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) points0 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) points1 = 8'($urandom);
      model_step();
      tick();
      compare_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
